inv_diffusion: RTL and testbench

- Decrypt-side inverse of the diffusion stage: InvMixColumns, then InvShiftRows, on one 4x4 byte state.
- Sits between the inverse-substitution and add-round-key stages of the decryption round.
- Processes one column per cycle through a shared GF(2^8) column unit.
- Uses a valid/ready handshake on both sides so it can stall against neighbouring stages.

---
 rtl/inv_diffusion_pkg.sv | 28 ++
 rtl/inv_mix_column.sv | 18 +
 rtl/inv_diffusion.sv | 104 ++++++++++
 tb/tb_inv_diffusion.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/inv_diffusion_pkg.sv
// Shared AES decrypt-side types, GF(2^8) helpers and the InvMixColumns coefficient matrix.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0][3:0] state_t;

  localparam byte_t GF_POLY = 8'h1B;

  // Indexed [out_row][in_row]; row 3 is the top byte of a column.
  localparam logic [3:0][3:0][3:0] INV_MIX_COEF = 64'hEBD9_9EBD_D9EB_BD9E;

  typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply by a 4-bit constant (used with 09/0B/0D/0E).
  function automatic byte_t gf_mul(input byte_t x, input logic [3:0] k);
    byte_t x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? x  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one column; col_in[3] is the top byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  byte_t [3:0] col_in,
  output byte_t [3:0] col_out
);

  always_comb begin
    col_out = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        col_out[r] = col_out[r] ^ gf_mul(col_in[k], INV_MIX_COEF[r][k]);
      end
    end
  end

endmodule

// File: rtl/inv_diffusion.sv
// InvMixColumns then InvShiftRows on a 4x4 state behind valid/ready handshakes.
// INV_DIFF_PARALLEL_EN: four column units and a single-cycle MIX instead of one shared unit.
module inv_diffusion
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t inv_diff_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t inv_diff_out
);

  fsm_t       state;
  logic [1:0] col;
  state_t     in_reg;
  state_t     res_reg;

`ifdef INV_DIFF_PARALLEL_EN
  byte_t [3:0][3:0] mix_all;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column u_col (
      .col_in  ({in_reg[3][c], in_reg[2][c], in_reg[1][c], in_reg[0][c]}),
      .col_out (mix_all[c])
    );
  end
`else
  byte_t [3:0] col_in;
  byte_t [3:0] col_out;

  always_comb begin
    col_in = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col_in[r] = in_reg[r][col];
    end
  end

  inv_mix_column u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= 2'd3;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      in_reg    <= '0;
      res_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_reg   <= inv_diff_in;
            col      <= 2'd3;
            in_ready <= 1'b0;
            state    <= MIX;
          end
        end
        MIX: begin
`ifdef INV_DIFF_PARALLEL_EN
          for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
              res_reg[r][c] <= mix_all[c][r];
            end
          end
          out_valid <= 1'b1;
          state     <= DONE;
`else
          for (int unsigned r = 0; r < 4; r++) begin
            res_reg[r][col] <= col_out[r];
          end
          col <= col - 2'd1;
          if (col == 2'd0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r rotates right by (3-r) columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar i = 0; i < 4; i++) begin : g_byte
      assign inv_diff_out[r][i] = res_reg[r][(i + 3 - r) % 4];
    end
  end

endmodule

// File: tb/tb_inv_diffusion.sv
// Directed and model-based checks of inv_diffusion (honours INV_DIFF_PARALLEL_EN).
module tb_inv_diffusion;
  import aes_pkg::*;

`ifdef INV_DIFF_PARALLEL_EN
  localparam int EXP_LAT = 1;
  localparam int EDGES_TO_COL1 = 1;
`else
  localparam int EXP_LAT = 4;
  localparam int EDGES_TO_COL1 = 2;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  state_t inv_diff_in = '0;
  logic   out_valid;
  logic   out_ready = 1'b0;
  state_t inv_diff_out;

  int checks = 0;
  int failures = 0;

  inv_diffusion dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inv_diff_in  (inv_diff_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .inv_diff_out (inv_diff_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic state_t cols(input byte_t b3, input byte_t b2, input byte_t b1, input byte_t b0);
    state_t s;
    for (int c = 0; c < 4; c++) begin
      s[3][c] = b3; s[2][c] = b2; s[1][c] = b1; s[0][c] = b0;
    end
    return s;
  endfunction

  function automatic byte_t fx2(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward ShiftRows then MixColumns, so the DUT should return the original.
  function automatic state_t forward(input state_t p);
    state_t s, m;
    byte_t a, b, c2, d;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        s[r][j] = p[r][(j + r + 1) % 4];
    for (int c = 0; c < 4; c++) begin
      a = s[3][c]; b = s[2][c]; c2 = s[1][c]; d = s[0][c];
      m[3][c] = fx2(a) ^ fx2(b) ^ b ^ c2 ^ d;
      m[2][c] = a ^ fx2(b) ^ fx2(c2) ^ c2 ^ d;
      m[1][c] = a ^ b ^ fx2(c2) ^ fx2(d) ^ d;
      m[0][c] = fx2(a) ^ a ^ b ^ c2 ^ fx2(d);
    end
    return m;
  endfunction

  // Returns #1 after the accepting edge; input bus is scrambled afterwards.
  task automatic put(input state_t s);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    inv_diff_in = s;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inv_diff_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take(output state_t r);
    @(negedge clk);
    out_ready = 1'b1;
    r = inv_diff_out;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("ready_after_xfer", 128'(in_ready), 128'(1));
    check_eq("valid_after_xfer", 128'(out_valid), 128'(0));
  endtask

  task automatic run(input string tag, input state_t s, input state_t exp);
    int lat;
    state_t r;
    put(s);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 128'(lat), 128'(EXP_LAT));
    take(r);
    check_eq(tag, r, exp);
  endtask

  initial begin
    state_t s, e, held, r;
    int lat;

    #12;
    check_eq("reset_in_ready", 128'(in_ready), 128'(1));
    check_eq("reset_out_valid", 128'(out_valid), 128'(0));
    check_eq("reset_out", inv_diff_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run("all_c6", cols(8'hC6, 8'hC6, 8'hC6, 8'hC6), cols(8'hC6, 8'hC6, 8'hC6, 8'hC6));

    s = cols(8'h01, 8'h01, 8'h01, 8'h01);
    s[3][3] = 8'h8E; s[2][3] = 8'h4D; s[1][3] = 8'hA1; s[0][3] = 8'hBC;
    e = cols(8'h01, 8'h01, 8'h01, 8'h01);
    e[3][3] = 8'hDB; e[2][2] = 8'h13; e[1][1] = 8'h53; e[0][0] = 8'h45;
    run("one_col", s, e);

    run("uniform_9f", cols(8'h9F, 8'hDC, 8'h58, 8'h9D), cols(8'hF2, 8'h0A, 8'h22, 8'h5C));

    // Stall in DONE with a competing request on the input side.
    put(s);
    wait_valid(lat);
    check_eq("stall_lat", 128'(lat), 128'(EXP_LAT));
    held = inv_diff_out;
    check_eq("stall_first", held, e);
    in_valid = 1'b1;
    inv_diff_in = cols(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 128'(out_valid), 128'(1));
      check_eq("stall_in_ready", 128'(in_ready), 128'(0));
      check_eq("stall_out", inv_diff_out, held);
    end
    in_valid = 1'b0;
    take(r);
    check_eq("stall_xfer", r, e);
    @(negedge clk);
    check_eq("stall_no_second", 128'(out_valid), 128'(0));

    // Reset mid-operation discards the partial result.
    put(cols(8'hD5, 8'hD5, 8'hD7, 8'hD6));
    repeat (EDGES_TO_COL1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out", inv_diff_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst_d5", cols(8'hD5, 8'hD5, 8'hD7, 8'hD6), cols(8'hD4, 8'hD4, 8'hD4, 8'hD5));

    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run("random_identity", forward(s), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
